victim_cache: RTL
=================

# victim_cache

Four-entry fully-associative victim buffer sitting directly beside the main cache datapath. It holds lines evicted from the main cache and supplies a hit line back through the main datapath's victim-input mux (`victim_data_o`/`victim_tag_o`/`victim_valid_o`/`victim_dirty_o`) as a one-cycle swap. Dirty lines pushed out of the buffer are written back to physical memory through a req/resp handshake owned by this block.

## Interface
- `s_offset`, 5, byte-offset bits of a line
- `s_index`, 4, main-cache index bits
- `s_tag`, 32-s_offset-s_index, main-cache tag width
- `s_line`, 8*2**s_offset, line width in bits
- `s_ways`, 2, log2 of entry count (4 entries)
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `lookup_addr`  in  32  address being looked up; offset bits ignored
- `hit`  out  1  a valid entry matches `lookup_addr[31:s_offset]`; combinational
- `victim_data_o`  out  s_line  data of the matching entry (0 when no hit)
- `victim_tag_o`  out  s_tag  tag field of the matching entry
- `victim_valid_o`  out  1  equals `hit`
- `victim_dirty_o`  out  1  dirty bit of the matching entry
- `swap`  in  1  replace the hit entry with the incoming line
- `insert`  in  1  place the incoming line in the buffer
- `ins_addr`  in  32  address of the incoming (evicted) line
- `ins_data`  in  s_line  incoming line data
- `ins_valid`  in  1  incoming line is valid
- `ins_dirty`  in  1  incoming line is dirty
- `ready`  out  1  buffer accepts `swap`/`insert`
- `pmem_address`  out  32  writeback address, offset bits zero
- `pmem_wdata`  out  s_line  writeback data
- `pmem_write`  out  1  writeback request
- `pmem_resp`  in  1  memory completed the write

## Operation
- Each entry: valid, dirty, line address (32-s_offset bits), data. LRU order is kept as per-entry 2-bit ages; the oldest entry has age 3.
- Lookup is fully combinational. `hit` = 1 only when `ready`=1; in WRITEBACK, `hit`=0.
- FSM states: IDLE, WRITEBACK. `ready` = (state == IDLE).
- IDLE, `swap`=1 with `hit`=1: the hit slot takes {ins_valid, ins_dirty, ins_addr, ins_data}. If `ins_valid`=1 it becomes MRU; if `ins_valid`=0 the slot is invalidated and its age is left unchanged. No pmem traffic.
- IDLE, `swap`=1 with `hit`=0: ignored.
- IDLE, `insert`=1 (with `swap`=0) and `ins_valid`=1: target is the lowest-numbered invalid slot; otherwise the LRU slot. The target is written and becomes MRU. If the displaced slot was valid and dirty, its address and data are latched into the writeback register and the FSM enters WRITEBACK.
- `swap` and `insert` asserted together: `swap` wins and `insert` is ignored. `insert` with `ins_valid`=0 is a no-op.
- WRITEBACK: `pmem_write`=1 with the latched address and data until `pmem_resp`=1, then IDLE. All `swap`/`insert` requests are ignored.
- The controller must not start a pmem read for a miss while `ready`=0.
- Age update on MRU touch of slot k: entries with age < age[k] increment, and age[k] becomes 0.

## Timing
- Reset values: all valid = 0, dirty = 0, ages = {0,1,2,3} for slots 0..3, state IDLE, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `ready`=1, `hit`=0.
- Reset mid-WRITEBACK aborts the write immediately (asynchronous) and discards the buffered line.
- `swap`/`insert` take effect at the sampling edge. `hit` reflects the new contents in the next cycle.
- `pmem_write` rises the cycle after the inserting edge and drops the cycle after `pmem_resp` is sampled high. `ready` returns high in that same cycle.
- Minimum WRITEBACK residency is 1 cycle (when `pmem_resp` is already high).

## Configuration
- `VICTIM_STATS_EN` defined: adds three 32-bit saturating output counters, cleared by reset:
  - `stat_hits`: swaps performed
  - `stat_inserts`: inserts accepted
  - `stat_writebacks`: completed writebacks
- Undefined: those ports and counters do not exist, and functional behaviour is identical.

## Structure
- `victim_cache_pkg` holds:
  - the state enum `vc_state_t` {IDLE, WRITEBACK}
  - the entry struct `vc_entry_t` {valid, dirty, laddr, data}
  - the constant `VC_ENTRIES` = 2**s_ways
- Sub-module `victim_lru` holds the age array. Inputs: touch enable and slot. Outputs: LRU slot index.

## Test plan
- After reset, `lookup_addr`=0x00001040 -> `hit`=0, `ready`=1, `pmem_write`=0.
- Insert clean lines 0x1000, 0x2000, 0x3000, 0x4000 -> slots 0..3 filled. Lookup 0x3000 -> `hit`=1, `victim_tag_o`=0x3000>>9, with data matching.
- Full buffer, all dirty; insert 0x5000 -> slot 0 (holding 0x1000) replaced. Next cycle `pmem_write`=1 with `pmem_address`=0x1000. Hold `pmem_resp`=0 for 3 cycles, then 1 -> `ready` returns 1 the following cycle.
- Swap on hit 0x2000 with incoming 0x6000 dirty -> lookup 0x2000 misses, lookup 0x6000 hits with `victim_dirty_o`=1, and slot becomes MRU.
- Assert `swap` and `insert` together on a hit -> only the swap occurs, `stat_inserts` is unchanged, and no pmem traffic.
- Drop `rst` during WRITEBACK -> `pmem_write`=0 immediately, all entries invalid, and `ready`=1 after release.

Source files
------------

// File: rtl/victim_cache_pkg.sv
// Shared geometry, state encoding and entry layout for the victim buffer.
// Optional statistics counters are enabled by defining VICTIM_STATS_EN.
package victim_cache_pkg;

    localparam int s_offset   = 5;
    localparam int s_index    = 4;
    localparam int s_tag      = 32 - s_offset - s_index;
    localparam int s_line     = 8 * 2**s_offset;
    localparam int s_ways     = 2;
    localparam int VC_ENTRIES = 2**s_ways;
    localparam int s_laddr    = 32 - s_offset;

    typedef enum logic {
        IDLE      = 1'b0,
        WRITEBACK = 1'b1
    } vc_state_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [s_laddr-1:0] laddr;
        logic [s_line-1:0]  data;
    } vc_entry_t;

endpackage

// File: rtl/victim_cache_lru.sv
// Age-based LRU tracker for the victim buffer; age 3 marks the eviction slot.
// Behaviour does not depend on VICTIM_STATS_EN.
module victim_lru
    import victim_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_touch_en,
    input  logic [s_ways-1:0] i_touch_slot,
    output logic [s_ways-1:0] o_lru_slot
);

    logic [s_ways-1:0] r_age [VC_ENTRIES];
    logic [s_ways-1:0] w_touch_age;

    assign w_touch_age = r_age[i_touch_slot];

    // Ages always form a permutation of 0..3, so exactly one slot holds the oldest age.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                r_age[i] <= s_ways'(i);
            end
        end else if (i_touch_en) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                if (s_ways'(i) == i_touch_slot) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_touch_age) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_lru_slot = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            if (&r_age[i]) begin
                o_lru_slot = s_ways'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache.sv
// Four-entry fully-associative victim buffer with one-cycle swap and dirty writeback.
// Define VICTIM_STATS_EN to add saturating hit/insert/writeback counters.
module victim_cache
    import victim_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       lookup_addr,
    output logic              hit,
    output logic [s_line-1:0] victim_data_o,
    output logic [s_tag-1:0]  victim_tag_o,
    output logic              victim_valid_o,
    output logic              victim_dirty_o,
    input  logic              swap,
    input  logic              insert,
    input  logic [31:0]       ins_addr,
    input  logic [s_line-1:0] ins_data,
    input  logic              ins_valid,
    input  logic              ins_dirty,
    output logic              ready,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    output logic              pmem_write,
    input  logic              pmem_resp
`ifdef VICTIM_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_inserts,
    output logic [31:0]       stat_writebacks
`endif
);

    logic [VC_ENTRIES-1:0] r_valid;
    logic [VC_ENTRIES-1:0] r_dirty;
    logic [s_laddr-1:0]    r_laddr [VC_ENTRIES];
    logic [s_line-1:0]     r_data  [VC_ENTRIES];

    vc_state_t          r_state;
    vc_state_t          w_next_state;
    logic [s_laddr-1:0] r_wb_laddr;
    logic [s_line-1:0]  r_wb_data;

    vc_entry_t         w_in;
    logic              w_match;
    logic [s_ways-1:0] w_hit_slot;
    logic              w_free;
    logic [s_ways-1:0] w_free_slot;
    logic [s_ways-1:0] w_lru_slot;
    logic [s_ways-1:0] w_ins_slot;
    logic              w_do_swap;
    logic              w_do_insert;
    logic              w_wb_start;
    logic              w_wb_done;
    logic              w_touch_en;
    logic [s_ways-1:0] w_touch_slot;
    logic              w_unused;

    assign w_in     = '{valid: ins_valid, dirty: ins_dirty,
                        laddr: ins_addr[31:s_offset], data: ins_data};
    assign w_unused = ^{lookup_addr[s_offset-1:0], ins_addr[s_offset-1:0]};

    // Descending scan so the lowest-numbered matching slot wins on duplicates.
    always_comb begin
        w_match    = 1'b0;
        w_hit_slot = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_laddr[i] == lookup_addr[31:s_offset])) begin
                w_match    = 1'b1;
                w_hit_slot = s_ways'(i);
            end
        end
    end

    always_comb begin
        w_free      = 1'b0;
        w_free_slot = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free      = 1'b1;
                w_free_slot = s_ways'(i);
            end
        end
    end

    assign w_ins_slot = w_free ? w_free_slot : w_lru_slot;

    assign hit            = w_match && (r_state == IDLE);
    assign victim_valid_o = hit;
    assign victim_data_o  = hit ? r_data[w_hit_slot] : '0;
    assign victim_tag_o   = hit ? r_laddr[w_hit_slot][s_laddr-1:s_index] : '0;
    assign victim_dirty_o = hit && r_dirty[w_hit_slot];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Swap has priority over insert; nothing is accepted while a writeback is pending.
    always_comb begin
        w_next_state = r_state;
        w_do_swap    = 1'b0;
        w_do_insert  = 1'b0;
        w_wb_start   = 1'b0;
        w_wb_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (swap) begin
                    w_do_swap = w_match;
                end else if (insert && ins_valid) begin
                    w_do_insert = 1'b1;
                    if (r_valid[w_ins_slot] && r_dirty[w_ins_slot]) begin
                        w_wb_start   = 1'b1;
                        w_next_state = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    w_wb_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // An invalidating swap leaves the slot's age where it was.
    assign w_touch_en   = (w_do_swap && ins_valid) || w_do_insert;
    assign w_touch_slot = w_do_swap ? w_hit_slot : w_ins_slot;

    victim_lru u_lru (
        .clk          (clk),
        .rst          (rst),
        .i_touch_en   (w_touch_en),
        .i_touch_slot (w_touch_slot),
        .o_lru_slot   (w_lru_slot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_do_swap) begin
            r_valid[w_hit_slot] <= w_in.valid;
            r_dirty[w_hit_slot] <= w_in.dirty;
        end else if (w_do_insert) begin
            r_valid[w_ins_slot] <= w_in.valid;
            r_dirty[w_ins_slot] <= w_in.dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_swap) begin
            r_laddr[w_hit_slot] <= w_in.laddr;
            r_data[w_hit_slot]  <= w_in.data;
        end else if (w_do_insert) begin
            r_laddr[w_ins_slot] <= w_in.laddr;
            r_data[w_ins_slot]  <= w_in.data;
        end
    end

    // Captures the displaced line before the insert overwrites it on the same edge.
    always_ff @(posedge clk) begin
        if (w_wb_start) begin
            r_wb_laddr <= r_laddr[w_ins_slot];
            r_wb_data  <= r_data[w_ins_slot];
        end
    end

    assign ready        = (r_state == IDLE);
    assign pmem_write   = (r_state == WRITEBACK);
    assign pmem_address = pmem_write ? {r_wb_laddr, {s_offset{1'b0}}} : '0;
    assign pmem_wdata   = pmem_write ? r_wb_data : '0;

`ifdef VICTIM_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_inserts;
    logic [31:0] r_stat_writebacks;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_hits       <= '0;
            r_stat_inserts    <= '0;
            r_stat_writebacks <= '0;
        end else begin
            if (w_do_swap)   r_stat_hits       <= sat_inc(r_stat_hits);
            if (w_do_insert) r_stat_inserts    <= sat_inc(r_stat_inserts);
            if (w_wb_done)   r_stat_writebacks <= sat_inc(r_stat_writebacks);
        end
    end

    assign stat_hits       = r_stat_hits;
    assign stat_inserts    = r_stat_inserts;
    assign stat_writebacks = r_stat_writebacks;
`endif

endmodule
